// File: rtl/rom_download_loader_pkg.sv
// Shared types and constants for the ROM download loader: FSM states,
// byte-enable codes and the captured-byte record.
package rom_download_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HAVE_LO,
    ISSUE,
    WAIT_ACK,
    FLUSH
  } state_t;

  // Byte enables as {hi, lo}.
  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  // One HPS byte as captured from the ioctl bus.
  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } byte_t;

  // Word offset inside the graphics region. The result is truncated to the
  // 23-bit port address, which drops bit 24 of the byte-level difference.
  function automatic logic [22:0] word_offset(input logic [23:0] waddr,
                                              input logic [23:0] base_waddr);
    return 23'(waddr - base_waddr);
  endfunction

endpackage

// File: rtl/rom_port_driver.sv
// One SDRAM controller write port: holds the toggle request and the
// address/enable/data registers for the single outstanding write.
module rom_port_driver (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [22:0] a_in,
  input  logic [1:0]  ds_in,
  input  logic [15:0] d_in,
  input  logic        ack,
  output logic        req,
  output logic        we,
  output logic [22:0] a,
  output logic [1:0]  ds,
  output logic [15:0] d,
  output logic        busy
);

  // Load a new write and flip req; the payload is frozen until the next issue.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the payload registers are reset as well because they drive
      // module outputs that must read zero out of reset.
      req <= 1'b0;
      we  <= 1'b0;
      a   <= '0;
      ds  <= '0;
      d   <= '0;
    end else if (issue) begin
      req <= ~req;
      we  <= 1'b1;
      a   <= a_in;
      ds  <= ds_in;
      d   <= d_in;
    end
  end

  assign busy = (req != ack);

endmodule

// File: rtl/rom_download_loader.sv
// ROM download front end: packs HPS bytes into 16-bit words and writes
// them to SDRAM port 1 (CPU ROM) or port 2 (graphics ROM), one at a time,
// back-pressuring the HPS through ioctl_wait. GFX_BASE must be even.
module rom_download_loader
  import rom_download_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [24:0] GFX_BASE  = 25'h040000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic        port2_we,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        done
);

  state_t      state;
  logic [23:0] lo_waddr;
  logic [7:0]  lo_data;
  byte_t       skid;
  logic        skid_valid;

  byte_t       live;
  byte_t       src;
  logic        src_valid;
  logic        strobe;
  logic        same_word;
  logic        stray_take;

  logic        launch;
  logic [23:0] launch_waddr;
  logic [1:0]  launch_ds;
  logic [15:0] launch_d;
  logic        to_gfx;
  logic [22:0] launch_word;
  logic        busy1;
  logic        busy2;
  logic        busy;

  assign strobe     = ioctl_download && ioctl_wr && (ioctl_index == ROM_INDEX);
  assign live       = '{addr: ioctl_addr, data: ioctl_dout};
  assign same_word  = (ioctl_addr[24:1] == lo_waddr);
  assign stray_take = strobe && !skid_valid;
  assign busy       = busy1 | busy2;

  // Byte seen by IDLE: a skidded byte is served before any live strobe.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    src       = live;
    src_valid = strobe;
    if (skid_valid) begin
      src       = skid;
      src_valid = 1'b1;
    end
  end

  // Decide whether this cycle launches a write, and what it carries.
  always_comb begin
    launch       = 1'b0;
    launch_waddr = lo_waddr;
    launch_ds    = DS_LO;
    launch_d     = {8'h00, lo_data};
    case (state)
      IDLE: begin
        if (src_valid && src.addr[0]) begin
          launch       = 1'b1;
          launch_waddr = src.addr[24:1];
          launch_ds    = DS_HI;
          launch_d     = {src.data, 8'h00};
        end
      end
      HAVE_LO: begin
        if (strobe) begin
          launch = 1'b1;
          if (ioctl_addr[0] && same_word) begin
            launch_ds = DS_WORD;
            launch_d  = {ioctl_dout, lo_data};
          end
        end else if (!ioctl_download) begin
          launch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign to_gfx      = (launch_waddr >= GFX_BASE[24:1]);
  assign launch_word = to_gfx ? word_offset(launch_waddr, GFX_BASE[24:1])
                              : launch_waddr[22:0];

  // Packing/issue FSM with registered ioctl_wait and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lo_waddr   <= '0;
      lo_data    <= '0;
      skid       <= '0;
      skid_valid <= 1'b0;
      ioctl_wait <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stray_take && (state == ISSUE || state == WAIT_ACK)) begin
        skid       <= live;
        skid_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          skid_valid <= 1'b0;
          ioctl_wait <= 1'b0;
          if (src_valid) begin
            if (src.addr[0]) begin
              state      <= ISSUE;
              ioctl_wait <= 1'b1;
            end else begin
              lo_waddr <= src.addr[24:1];
              lo_data  <= src.data;
              state    <= HAVE_LO;
            end
          end
        end
        HAVE_LO: begin
          if (strobe) begin
            ioctl_wait <= 1'b1;
            if (ioctl_addr[0] && same_word) begin
              state <= ISSUE;
            end else begin
              // The pending lo goes out alone; this byte waits in the skid.
              skid       <= live;
              skid_valid <= 1'b1;
              state      <= FLUSH;
            end
          end else if (!ioctl_download) begin
            ioctl_wait <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          ioctl_wait <= 1'b1;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!busy) begin
            state      <= IDLE;
            ioctl_wait <= skid_valid || stray_take;
            done       <= !ioctl_download && !skid_valid;
          end
        end
        FLUSH: begin
          if (!busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rom_port_driver u_port1 (
    .clk   (clk),
    .reset (reset),
    .issue (launch && !to_gfx),
    .a_in  (launch_word),
    .ds_in (launch_ds),
    .d_in  (launch_d),
    .ack   (port1_ack),
    .req   (port1_req),
    .we    (port1_we),
    .a     (port1_a),
    .ds    (port1_ds),
    .d     (port1_d),
    .busy  (busy1)
  );

  rom_port_driver u_port2 (
    .clk   (clk),
    .reset (reset),
    .issue (launch && to_gfx),
    .a_in  (launch_word),
    .ds_in (launch_ds),
    .d_in  (launch_d),
    .ack   (port2_ack),
    .req   (port2_req),
    .we    (port2_we),
    .a     (port2_a),
    .ds    (port2_ds),
    .d     (port2_d),
    .busy  (busy2)
  );

endmodule

// File: tb/tb_rom_download_loader.sv
// Scoreboard bench for rom_download_loader: a byte-level reference model
// queues the expected port writes; a monitor pops them as reqs toggle.
module tb_rom_download_loader;

  localparam logic [7:0]  ROM_INDEX = 8'd0;
  localparam logic [24:0] GFX_BASE  = 25'h040000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        port1_req, port1_we, port2_req, port2_we, done;
  logic        port1_ack = 1'b0;
  logic        port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;

  typedef struct {
    bit          port2;
    logic [22:0] a;
    logic [1:0]  ds;
    logic [7:0]  lo;
    logic [7:0]  hi;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_cnt[2] = '{0, 0};
  int   toggles[2] = '{0, 0};
  int   exp_done = 0;
  int   done_seen = 0;
  int   ack_delay = 0;  // 0 selects a random 1..4 cycle ack latency

  // Reference model state: the even byte still waiting for its partner.
  logic        m_lo_valid = 1'b0;
  logic [24:0] m_lo_addr = '0;
  logic [7:0]  m_lo_data = '0;

  rom_download_loader #(.ROM_INDEX(ROM_INDEX), .GFX_BASE(GFX_BASE)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we),
    .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_we(port2_we),
    .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input string info);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endtask

  // Expected write: route by byte address, port address is the word offset.
  function automatic void emit(input logic [24:0] addr, input logic [1:0] ds,
                               input logic [7:0] lo, input logic [7:0] hi);
    exp_t e;
    logic [24:0] off;
    e.port2 = (addr >= GFX_BASE);
    off = e.port2 ? addr - GFX_BASE : addr;
    e.a  = off[23:1];
    e.ds = ds;
    e.lo = lo;
    e.hi = hi;
    exp_q.push_back(e);
    exp_cnt[int'(e.port2)]++;
  endfunction

  function automatic void model_byte(input logic [24:0] addr, input logic [7:0] data);
    if (addr[0]) begin
      if (m_lo_valid && (addr >> 1) == (m_lo_addr >> 1)) begin
        emit(m_lo_addr, 2'b11, m_lo_data, data);
      end else begin
        if (m_lo_valid) emit(m_lo_addr, 2'b01, m_lo_data, 8'h00);
        emit(addr, 2'b10, 8'h00, data);
      end
      m_lo_valid = 1'b0;
    end else begin
      if (m_lo_valid) emit(m_lo_addr, 2'b01, m_lo_data, 8'h00);
      m_lo_valid = 1'b1;
      m_lo_addr  = addr;
      m_lo_data  = data;
    end
  endfunction

  // HPS side: honours ioctl_wait, strobes one byte. Entered and left at a negedge.
  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data,
                           input logic [7:0] idx);
    int t = 0;
    while (ioctl_wait && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      check(1'b0, "hps_wait_timeout", $sformatf("ioctl_wait=%b after %0d cycles, want 0", ioctl_wait, t));
      return;
    end
    if (idx == ROM_INDEX && ioctl_download) model_byte(addr, data);
    ioctl_addr  = addr;
    ioctl_dout  = data;
    ioctl_index = idx;
    ioctl_wr    = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic quiesce();
    int t = 0;
    repeat (2) @(negedge clk);
    while ((ioctl_wait || port1_req != port1_ack || port2_req != port2_ack) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300)
      check(1'b0, "quiesce_timeout", $sformatf("ioctl_wait=%b req1=%b ack1=%b req2=%b ack2=%b",
            ioctl_wait, port1_req, port1_ack, port2_req, port2_ack));
    repeat (3) @(negedge clk);
  endtask

  task automatic start_window();
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_window();
    int t = 0;
    while (ioctl_wait && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (m_lo_valid) begin
      emit(m_lo_addr, 2'b01, m_lo_data, 8'h00);
      exp_done++;
      m_lo_valid = 1'b0;
    end
    ioctl_download = 1'b0;
    quiesce();
  endtask

  // SDRAM controller stand-ins: return ack a few cycles after each req toggle.
  initial begin : ack1_model
    int d;
    forever begin
      @(posedge clk);
      #1;
      if (reset) port1_ack = 1'b0;
      else if (port1_req != port1_ack) begin
        d = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 4));
        repeat (d) @(posedge clk);
        #1 port1_ack = port1_req;
      end
    end
  end

  initial begin : ack2_model
    int d;
    forever begin
      @(posedge clk);
      #1;
      if (reset) port2_ack = 1'b0;
      else if (port2_req != port2_ack) begin
        d = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 4));
        repeat (d) @(posedge clk);
        #1 port2_ack = port2_req;
      end
    end
  end

  // Monitor: on every req toggle pop and compare; while busy the payload must
  // hold and ioctl_wait must stay high; done must follow an ack match by 1 cycle.
  initial begin : monitor
    logic [1:0]  prev_req, rq, ak, trk, stable;
    logic        prev_match, match, rise_prev;
    logic [22:0] av[2], snap_a[2];
    logic [1:0]  dsv[2], snap_ds[2];
    logic [15:0] dv[2], snap_d[2];
    exp_t        e;
    bit          ok;
    prev_req = '0; trk = '0; stable = '1; prev_match = 1'b1; rise_prev = 1'b0;
    forever begin
      @(negedge clk);
      rq = {port2_req, port1_req};
      ak = {port2_ack, port1_ack};
      av[0] = port1_a;  dsv[0] = port1_ds; dv[0] = port1_d;
      av[1] = port2_a;  dsv[1] = port2_ds; dv[1] = port2_d;
      if (reset) begin
        prev_req = rq; trk = '0; prev_match = 1'b1; rise_prev = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (rq[p] != prev_req[p]) begin
            toggles[p]++;
            if (exp_q.size() == 0) begin
              check(1'b0, "unexpected_write", $sformatf("port%0d a=%h ds=%b d=%h, want no write",
                    p + 1, av[p], dsv[p], dv[p]));
            end else begin
              e  = exp_q.pop_front();
              ok = (int'(e.port2) == p) && (av[p] == e.a) && (dsv[p] == e.ds) &&
                   (!e.ds[0] || dv[p][7:0] == e.lo) && (!e.ds[1] || dv[p][15:8] == e.hi);
              check(ok, "write", $sformatf("got port%0d a=%h ds=%b d=%h, want port%0d a=%h ds=%b lo=%h hi=%h",
                    p + 1, av[p], dsv[p], dv[p], int'(e.port2) + 1, e.a, e.ds, e.lo, e.hi));
            end
            trk[p] = 1'b1;
            stable[p] = ioctl_wait;
            snap_a[p] = av[p]; snap_ds[p] = dsv[p]; snap_d[p] = dv[p];
          end else if (trk[p]) begin
            if (rq[p] != ak[p]) begin
              if (av[p] != snap_a[p] || dsv[p] != snap_ds[p] || dv[p] != snap_d[p] || !ioctl_wait)
                stable[p] = 1'b0;
            end else begin
              check(stable[p], "hold_stable", $sformatf("port%0d payload or ioctl_wait moved while busy, want held",
                    p + 1));
              trk[p] = 1'b0;
            end
          end
        end
        if (rq[0] != ak[0] && rq[1] != ak[1]) stable = '0;
        if (done) begin
          done_seen++;
          check(rise_prev && !ioctl_download, "done_timing",
                $sformatf("done with ack_match_prev=%b download=%b, want 1/0", rise_prev, ioctl_download));
        end
        match      = (rq == ak);
        rise_prev  = match && !prev_match;
        prev_match = match;
        prev_req   = rq;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic        r1, r2;
    logic [24:0] addr, base;
    logic [7:0]  idx;
    int          r;

    repeat (3) @(negedge clk);
    check({ioctl_wait, port1_req, port1_we, port1_a, port1_ds, port1_d,
           port2_req, port2_we, port2_a, port2_ds, port2_d, done} == '0,
          "reset_outputs", "some output nonzero during reset, want all 0");
    reset = 1'b0;
    @(negedge clk);

    // Pair on port 1, ack three cycles after req.
    ack_delay = 3;
    start_window();
    r1 = port1_req;
    send_byte(25'h000000, 8'h12, ROM_INDEX);
    check(!ioctl_wait && port1_req == r1, "lo_hold",
          $sformatf("ioctl_wait=%b req1=%b after even byte, want 0/%b", ioctl_wait, port1_req, r1));
    send_byte(25'h000001, 8'h34, ROM_INDEX);
    check(port1_req == !r1 && ioctl_wait && port1_we, "issue_timing",
          $sformatf("req1=%b wait=%b we=%b one cycle after odd byte, want %b/1/1",
                    port1_req, ioctl_wait, port1_we, !r1));
    quiesce();

    // Pair on port 2.
    send_byte(25'h040000, 8'hAA, ROM_INDEX);
    send_byte(25'h040001, 8'hBB, ROM_INDEX);
    quiesce();

    // Lone lo flushed by the window closing; done must follow.
    send_byte(25'h000010, 8'h55, ROM_INDEX);
    end_window();

    // Even, even, odd: flush then a full word.
    start_window();
    send_byte(25'h000020, 8'h01, ROM_INDEX);
    send_byte(25'h000022, 8'h02, ROM_INDEX);
    send_byte(25'h000023, 8'h03, ROM_INDEX);
    quiesce();

    // Long ack stall.
    ack_delay = 20;
    send_byte(25'h000030, 8'h77, ROM_INDEX);
    send_byte(25'h000031, 8'h88, ROM_INDEX);
    quiesce();
    ack_delay = 0;

    // Foreign index is ignored.
    r1 = port1_req;
    r2 = port2_req;
    for (int i = 0; i < 3; i++) begin
      send_byte(25'h000040 + 25'(i), 8'(i), 8'd1);
      check(!ioctl_wait && port1_req == r1 && port2_req == r2, "foreign_index",
            $sformatf("wait=%b req1=%b req2=%b, want 0/%b/%b", ioctl_wait, port1_req, port2_req, r1, r2));
    end
    end_window();

    // Randomized windows over both ports and the top of the address space.
    for (int w = 0; w < 8; w++) begin
      start_window();
      r = int'($urandom_range(0, 2));
      base = (r == 0) ? 25'h0 : (r == 1) ? GFX_BASE : 25'h1FFFFC0;
      addr = base + 25'($urandom_range(0, 15));
      for (int b = 0; b < 24; b++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6) addr = addr + 25'd1;
        else if (r < 8) addr = base + 25'($urandom_range(0, 31));
        else addr = addr + 25'd2;
        idx = ($urandom_range(0, 9) == 0) ? 8'd1 : ROM_INDEX;
        send_byte(addr, 8'($urandom), idx);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      end_window();
    end

    // Reset while a write is waiting for its ack.
    ack_delay = 30;
    start_window();
    send_byte(25'h000100, 8'hC1, ROM_INDEX);
    send_byte(25'h000101, 8'hC2, ROM_INDEX);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check({ioctl_wait, port1_req, port1_we, port1_a, port1_ds, port1_d,
           port2_req, port2_we, port2_a, port2_ds, port2_d, done} == '0,
          "reset_abandon", $sformatf("req1=%b wait=%b a1=%h, want all outputs 0", port1_req, ioctl_wait, port1_a));
    reset = 1'b0;
    m_lo_valid = 1'b0;
    ioctl_download = 1'b0;
    repeat (40) @(negedge clk);

    check(exp_q.size() == 0, "queue_drained", $sformatf("%0d writes never seen, want 0", exp_q.size()));
    check(toggles[0] == exp_cnt[0], "port1_toggles", $sformatf("got %0d, want %0d", toggles[0], exp_cnt[0]));
    check(toggles[1] == exp_cnt[1], "port2_toggles", $sformatf("got %0d, want %0d", toggles[1], exp_cnt[1]));
    check(done_seen == exp_done, "done_count", $sformatf("got %0d, want %0d", done_seen, exp_done));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_download_loader.md
# rom_download_loader

Upstream feeder for the dual-port SDRAM controller during ROM download. It accepts the HPS byte stream (ioctl_*), packs byte pairs into 16-bit words, and routes each word to one of two controller ports. Port 1 (banks 0/1) receives CPU ROM; port 2 (banks 2/3) receives graphics ROM. Words are issued on the controller's toggle req/ack handshake, and ioctl_wait back-pressures the HPS while a write is outstanding.

## Interface
Parameters:
- ROM_INDEX, 8'd0: ioctl_index value that this block accepts; all other indices are ignored.
- GFX_BASE, 25'h040000: first byte address routed to port 2. Lower addresses go to port 1.

Ports:
- clk  in  1  system clock; same clock as the SDRAM controller.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download index.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  stall request to the HPS.
- port1_req  out  1  toggle request, port 1.
- port1_ack  in  1  port-1 done when it equals port1_req.
- port1_we  out  1  always 1 while downloading.
- port1_a  out  23  word address [23:1].
- port1_ds  out  2  byte enables, {hi, lo}.
- port1_d  out  16  write data.
- port2_req, port2_ack, port2_we, port2_a, port2_ds, port2_d: same as port 1, for port 2.
- done  out  1  pulses for 1 cycle after the final word of a download has been acked.

## Operation
- A byte is accepted only when ioctl_download=1, ioctl_wr=1, and ioctl_index=ROM_INDEX.
- Byte lanes: an even address goes to d[7:0]; an odd address goes to d[15:8].
- Routing: if addr < GFX_BASE, the word goes to port 1 with a = addr[23:1]. Otherwise it goes to port 2 with a = (addr − GFX_BASE)[23:1], using 25-bit subtraction and discarding bit 24.
- FSM states: IDLE, HAVE_LO, ISSUE, WAIT_ACK, FLUSH.
- IDLE:
  - An even byte latches into lo_byte and the word address is stored. Next state is HAVE_LO.
  - A lone odd byte issues with ds=2'b10 and goes to ISSUE.
- HAVE_LO, on an odd byte:
  - If the byte's addr[24:1] equals the stored word address, issue the full word with ds=2'b11.
  - Otherwise, first issue the pending lo with ds=2'b01 (enter FLUSH), then issue the odd byte with ds=2'b10.
- HAVE_LO, on an even byte: flush the pending lo with ds=2'b01, then latch the new byte.
- HAVE_LO, when ioctl_download falls: flush with ds=2'b01.
- ISSUE: drive the selected port's a/ds/d/we and toggle its req. Next state is WAIT_ACK.
- WAIT_ACK: hold until port_ack == port_req, then return to IDLE. If the download window has closed with nothing pending, assert done.
- Only one request is outstanding at any time. Ports are never both pending.
- ioctl_wait = 1 in any state other than IDLE or HAVE_LO, or whenever a flush is queued.
- While ioctl_wait=1 the HPS does not strobe. A strobe that arrives anyway in ISSUE or WAIT_ACK is captured in a one-byte skid register and processed on return to IDLE. A second such strobe is dropped.
- Writes only: port*_we = 1; the port*_q outputs are unused.

## Timing
- Reset values: every output is 0 (including req, a, ds, d, we, ioctl_wait, done). State is IDLE, the skid register is empty, and lo is invalid.
- Reset during WAIT_ACK abandons the request; req returns to 0. The controller is reset on the same reset.
- Odd-byte strobe at cycle N (pairing with a pending lo):
  - N+1: ISSUE. a/ds/d are valid and req toggles (registered). ioctl_wait=1.
  - Outputs hold stable until ack matches.
- Ack match seen at cycle M: IDLE at M+1, and ioctl_wait drops at M+1.
- done is asserted exactly 1 cycle after the last ack match, and only when ioctl_download=0.
- a, ds, and d must not change while req != ack.

## Structure
- Shared package holds the state enum (IDLE, HAVE_LO, ISSUE, WAIT_ACK, FLUSH) and the DS_LO/DS_HI/DS_WORD constants.
- One sub-module, rom_port_driver, instantiated twice. It holds the req toggle register, the a/ds/d registers, and a busy = (req != ack) flag.
- The top level holds the FSM, byte packing, routing, and the skid register.

## Test plan
- Byte 0x12 @ 0x000000, then 0x34 @ 0x000001, with ack returned 3 cycles after req → port1: a=0, d=0x3412, ds=11. Exactly one port1 req toggle; no port2 activity.
- Byte 0xAA @ 0x040000, then 0xBB @ 0x040001 → port2: a=0, d=0xBBAA, ds=11.
- Byte 0x55 @ 0x000010, then ioctl_download falls → port1: a=0x8, ds=01, d[7:0]=0x55. done pulses 1 cycle after ack.
- Even byte 0x01 @ 0x20, then even byte 0x02 @ 0x22 → first write a=0x10, ds=01. Then, after 0x03 @ 0x23, write a=0x11, d=0x0302, ds=11.
- Odd-byte strobe while ack is held off for 20 cycles → ioctl_wait=1 for the whole stall. Outputs stay stable; exactly one req toggle.
- Any strobe with ioctl_index=1 → no req toggles; ioctl_wait stays 0.
